time_bin_histogram: RTL and testbench

TIME_BIN_HISTOGRAM -- requirements
Module: time_bin_histogram

---
 rtl/time_bin_histogram.sv | 144 ++++++++++++++
 tb/tb_time_bin_histogram.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_bin_histogram.sv
// Time-bin histogram: per-bin saturating counters with clear sweep
// and a valid/ready readout stream.
module time_bin_histogram #(
  parameter int NUM_BINS   = 128,
  parameter int BIN_ADDR_W = 7,
  parameter int COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cmd,
  input  logic                  hit_valid,
  input  logic [BIN_ADDR_W-1:0] hit_bin,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [COUNT_W-1:0]    rd_data,
  output logic [BIN_ADDR_W-1:0] rd_bin,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  sat_flag,
  output logic [15:0]           drop_count
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_ACCUM,
    S_READ
  } state_e;

  localparam logic [BIN_ADDR_W-1:0] LAST_IDX =
    BIN_ADDR_W'(NUM_BINS - 1);
  localparam logic [BIN_ADDR_W:0] NB_EXT =
    (BIN_ADDR_W + 1)'(NUM_BINS);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  state_e                  state_q, state_d;
  // One index serves both the clear sweep and the readout walk.
  logic [BIN_ADDR_W-1:0]   idx_q, idx_d;
  logic                    sat_q, sat_d;
  logic [15:0]             drop_q, drop_d;
  logic [15:0]             drop_base;
  logic [COUNT_W-1:0]      bins_q [NUM_BINS];

  logic                    in_range;
  logic                    idx_last;
  logic                    first_clr;
  logic                    do_inc;
  logic                    do_drop;
  logic [COUNT_W-1:0]      cur_cnt;
  logic [COUNT_W-1:0]      inc_cnt;

  assign in_range  = {1'b0, hit_bin} < NB_EXT;
  assign idx_last  = idx_q == LAST_IDX;
  assign first_clr = (state_q == S_CLEAR) && (idx_q == '0);

  // Saturating increment of the addressed bin; a fresh read every
  // cycle keeps back-to-back hits to one bin from losing updates.
  assign cur_cnt = bins_q[hit_bin];
  assign inc_cnt = (cur_cnt == CNT_MAX) ? cur_cnt
                                        : cur_cnt + 1'b1;

  // Next state, index, sticky flag and drop counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    do_inc  = 1'b0;
    do_drop = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        do_drop = hit_valid;
        idx_d   = idx_q + 1'b1;
        if (idx_last) begin
          state_d = S_ACCUM;
          idx_d   = '0;
        end
      end
      S_ACCUM: begin
        do_inc  = hit_valid && in_range;
        do_drop = hit_valid && !in_range;
        if (cmd == 2'b01) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end else if (cmd == 2'b10) begin
          state_d = S_READ;
          idx_d   = '0;
        end
      end
      S_READ: begin
        do_drop = hit_valid;
        if (rd_ready) begin
          idx_d = idx_q + 1'b1;
          if (idx_last) begin
            state_d = S_ACCUM;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
        idx_d   = '0;
      end
    endcase
    drop_base = first_clr ? 16'h0 : drop_q;
    drop_d    = drop_base;
    if (do_drop && (drop_base != DROP_MAX)) begin
      drop_d = drop_base + 16'h1;
    end
    sat_d = first_clr ? 1'b0
          : (sat_q | (do_inc && (inc_cnt == CNT_MAX)));
  end

  // Control registers; reset restarts the clear sweep at bin 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      sat_q   <= 1'b0;
      drop_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      drop_q  <= drop_d;
    end
  end

  // Bin storage: zeroed by the sweep, bumped by in-range hits.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      bins_q[idx_q] <= '0;
    end else if (do_inc) begin
      bins_q[hit_bin] <= inc_cnt;
    end
  end

  assign busy       = state_q != S_ACCUM;
  assign rd_valid   = state_q == S_READ;
  assign rd_bin     = rd_valid ? idx_q : '0;
  assign rd_last    = rd_valid && idx_last;
  assign rd_data    = rd_valid ? bins_q[idx_q] : '0;
  assign sat_flag   = sat_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_time_bin_histogram.sv
// Directed bench for time_bin_histogram: default, 4-bit counter
// and 100-bin instances driven from vector tables.
module tb_time_bin_histogram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic [1:0]  cmd   [3];
  logic        hv    [3];
  logic [6:0]  hb    [3];
  logic        rdy   [3];
  logic        rv    [3];
  logic [15:0] rdat  [3];
  logic [3:0]  rd4;
  logic [6:0]  rbin  [3];
  logic        rlast [3];
  logic        busy  [3];
  logic        sat   [3];
  logic [15:0] dc    [3];

  assign rdat[1] = {12'd0, rd4};

  time_bin_histogram u0 (
    .clk(clk), .rst(rst[0]), .cmd(cmd[0]),
    .hit_valid(hv[0]), .hit_bin(hb[0]),
    .rd_valid(rv[0]), .rd_ready(rdy[0]),
    .rd_data(rdat[0]), .rd_bin(rbin[0]),
    .rd_last(rlast[0]), .busy(busy[0]),
    .sat_flag(sat[0]), .drop_count(dc[0])
  );

  time_bin_histogram #(.COUNT_W(4)) u1 (
    .clk(clk), .rst(rst[1]), .cmd(cmd[1]),
    .hit_valid(hv[1]), .hit_bin(hb[1]),
    .rd_valid(rv[1]), .rd_ready(rdy[1]),
    .rd_data(rd4), .rd_bin(rbin[1]),
    .rd_last(rlast[1]), .busy(busy[1]),
    .sat_flag(sat[1]), .drop_count(dc[1])
  );

  time_bin_histogram #(.NUM_BINS(100)) u2 (
    .clk(clk), .rst(rst[2]), .cmd(cmd[2]),
    .hit_valid(hv[2]), .hit_bin(hb[2]),
    .rd_valid(rv[2]), .rd_ready(rdy[2]),
    .rd_data(rdat[2]), .rd_bin(rbin[2]),
    .rd_last(rlast[2]), .busy(busy[2]),
    .sat_flag(sat[2]), .drop_count(dc[2])
  );

  typedef struct packed {
    logic [6:0]  bin;
    logic [15:0] data;
    logic        last;
  } wrec_t;

  typedef struct {
    int phase;
    int d;
    int bin;
    int nhits;
    int exp;
  } vec_t;

  int    n_run  = 0;
  int    n_fail = 0;
  wrec_t wq [3][$];
  vec_t  tbl [5];

  task automatic chk(string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic hits(int d, int b, int n);
    hv[d] = 1'b1;
    hb[d] = 7'(b);
    repeat (n) begin
      @(posedge clk); #1;
    end
    hv[d] = 1'b0;
  endtask

  task automatic apply_phase(int p);
    foreach (tbl[i]) begin
      if (tbl[i].phase == p && tbl[i].nhits > 0)
        hits(tbl[i].d, tbl[i].bin, tbl[i].nhits);
    end
  endtask

  task automatic wait_idle(int d, output int n);
    n = 0;
    while (busy[d] && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic readout(int d, bit tog, int cmd_hit,
                         int rd_hits, output int cyc);
    bit    pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int    k = 0;
    bit    stalled = 1'b0;
    wrec_t cur;
    wrec_t prv;
    wq[d].delete();
    cmd[d] = 2'b10;
    if (cmd_hit >= 0) begin
      hv[d] = 1'b1;
      hb[d] = 7'(cmd_hit);
    end
    @(posedge clk); #1;
    cmd[d] = 2'b00;
    hv[d]  = 1'b0;
    cyc    = 0;
    while (busy[d] && cyc < 2000) begin
      cur = {rbin[d], rdat[d], rlast[d]};
      if (stalled) begin
        n_run++;
        if (cur !== prv) begin
          n_fail++;
          $display("FAIL stall_hold d%0d: got %h, want %h",
                   d, cur, prv);
        end
      end
      rdy[d] = tog ? pat[k % 4] : 1'b1;
      hv[d]  = k < rd_hits;
      hb[d]  = 7'd5;
      if (rdy[d] && rv[d]) wq[d].push_back(cur);
      stalled = !rdy[d];
      prv     = cur;
      k++;
      @(posedge clk); #1;
      cyc++;
    end
    rdy[d] = 1'b0;
    hv[d]  = 1'b0;
    chk("rd_timeout", 32'(cyc < 2000), 1);
  endtask

  task automatic check_words(int d, int nb, int phase);
    int e;
    chk("word_count", wq[d].size(), nb);
    for (int i = 0; i < wq[d].size(); i++) begin
      e = 0;
      foreach (tbl[j]) begin
        if (tbl[j].phase == phase && tbl[j].d == d &&
            tbl[j].bin == i)
          e = tbl[j].exp;
      end
      n_run++;
      if (wq[d][i].bin !== 7'(i) ||
          wq[d][i].data !== 16'(e) ||
          wq[d][i].last !== (i == nb - 1)) begin
        n_fail++;
        $display("FAIL word d%0d i%0d: got bin=%0d data=%0d last=%0d, want bin=%0d data=%0d last=%0d",
                 d, i, wq[d][i].bin, wq[d][i].data,
                 wq[d][i].last, i, e, i == nb - 1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int fall [3];
    tbl[0] = '{1, 0, 3, 5, 5};
    tbl[1] = '{1, 0, 127, 2, 2};
    tbl[2] = '{1, 0, 10, 0, 1};
    tbl[3] = '{2, 1, 0, 20, 15};
    tbl[4] = '{3, 2, 100, 1, 0};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; cmd[d] = 2'b00; hv[d] = 1'b0;
      hb[d] = 7'd0;  rdy[d] = 1'b0;  fall[d] = -1;
    end
    #12;
    chk("rst_valid", rv[0], 0);
    chk("rst_data", rdat[0], 0);
    chk("rst_bin", rbin[0], 0);
    chk("rst_last", rlast[0], 0);
    chk("rst_busy", busy[0], 1);
    chk("rst_sat", sat[0], 0);
    chk("rst_drop", dc[0], 0);

    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    for (int c = 1; c <= 140; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++)
        if (fall[d] < 0 && !busy[d]) fall[d] = c;
    end
    chk("clr_lat_u0", fall[0], 128);
    chk("clr_lat_u1", fall[1], 128);
    chk("clr_lat_u2", fall[2], 100);

    readout(0, 1'b0, -1, 0, cyc);
    chk("rd_len_u0", cyc, 128);
    check_words(0, 128, 0);

    apply_phase(1);
    readout(0, 1'b1, 10, 0, cyc);
    check_words(0, 128, 1);
    chk("drop_u0", dc[0], 0);
    chk("sat_u0", sat[0], 0);

    chk("sat_u1_pre", sat[1], 0);
    hits(1, 0, 14);
    chk("sat_u1_14", sat[1], 0);
    apply_phase(2);
    chk("sat_u1_post", sat[1], 1);
    readout(1, 1'b0, -1, 0, cyc);
    check_words(1, 128, 2);

    cmd[1] = 2'b01;
    @(posedge clk); #1;
    cmd[1] = 2'b00;
    chk("clr_busy_u1", busy[1], 1);
    wait_idle(1, cyc);
    chk("clr_cmd_lat_u1", cyc, 128);
    chk("clr_sat_u1", sat[1], 0);
    readout(1, 1'b0, -1, 0, cyc);
    check_words(1, 128, 0);

    apply_phase(3);
    chk("drop_u2_oob", dc[2], 1);
    readout(2, 1'b0, -1, 3, cyc);
    chk("rd_len_u2", cyc, 100);
    check_words(2, 100, 3);
    chk("drop_u2_read", dc[2], 4);

    wq[0].delete();
    cmd[0] = 2'b10;
    @(posedge clk); #1;
    cmd[0] = 2'b00;
    rdy[0] = 1'b1;
    cyc = 0;
    while (wq[0].size() < 50 && cyc < 500) begin
      if (rv[0]) wq[0].push_back({rbin[0], rdat[0], rlast[0]});
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_idx", rbin[0], 50);
    rst[0] = 1'b1;
    #1;
    chk("mid_rst_valid", rv[0], 0);
    chk("mid_rst_busy", busy[0], 1);
    chk("mid_rst_bin", rbin[0], 0);
    rdy[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    wait_idle(0, cyc);
    chk("mid_rst_clr_lat", cyc, 128);
    readout(0, 1'b0, -1, 0, cyc);
    check_words(0, 128, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
